// File: rtl/multi_core_controller_pkg.sv
// Shared encodings for the multi-core run-control sequencer: per-core state codes,
// command opcodes and the core-index width derivation.
package multi_core_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_ABORT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_RESET  = 2'd0,
    OP_START  = 2'd1,
    OP_ABORT  = 2'd2,
    OP_CLRIRQ = 2'd3
  } op_e;

  function automatic int core_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_run_fsm.sv
// Run-control state machine for one core: reset hold, execute enable, cycle count,
// timeout watchdog and interrupt-pending flag. Commands arrive pre-validated.
module core_run_fsm
  import multi_core_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int STAT_WIDTH = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int RST_CYCLES = 4,
  parameter int DONE_BIT   = 0
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  cmd_en,
  input  op_e                   cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_timeout,
  input  logic [STAT_WIDTH-1:0] core_stat,
  output logic                  core_rst,
  output logic                  core_exec,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            state,
  output logic [CNT_WIDTH-1:0]  cycles,
  output logic                  irq_pend,
  output logic                  irq_pend_next
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  core_rst_q, core_rst_d;
  logic                  core_exec_q, core_exec_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_WIDTH-1:0]  cycles_q, cycles_d;
  logic [CNT_WIDTH-1:0]  timeout_q, timeout_d;
  logic                  irq_pend_q, irq_pend_d;
  logic [RCW-1:0]        rst_cnt_q, rst_cnt_d;
  logic                  run_after_q, run_after_d;
  logic [CNT_WIDTH:0]    cyc_plus1;
  logic                  tmo_hit;
  logic                  event_set;

  always_comb begin
    state_d     = state_q;
    core_rst_d  = core_rst_q;
    core_exec_d = core_exec_q;
    mem_addr_d  = mem_addr_q;
    cycles_d    = cycles_q;
    timeout_d   = timeout_q;
    irq_pend_d  = irq_pend_q;
    rst_cnt_d   = rst_cnt_q;
    run_after_d = run_after_q;
    event_set   = 1'b0;

    cyc_plus1 = {1'b0, cycles_q} + (CNT_WIDTH + 1)'(1);
    tmo_hit   = (timeout_q != '0) && (cyc_plus1 == {1'b0, timeout_q});

    if (core_exec_q && (cycles_q != '1)) begin
      cycles_d = cyc_plus1[CNT_WIDTH-1:0];
    end

    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == '0) begin
          core_rst_d  = 1'b0;
          core_exec_d = run_after_q;
          state_d     = run_after_q ? ST_RUN : ST_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        // Completion takes priority over the watchdog on the same cycle.
        if (core_stat[DONE_BIT]) begin
          state_d     = ST_DONE;
          core_exec_d = 1'b0;
          event_set   = 1'b1;
        end else if (tmo_hit) begin
          state_d     = ST_TIMEOUT;
          core_exec_d = 1'b0;
          event_set   = 1'b1;
        end
      end
      default: core_rst_d = 1'b0;
    endcase

    if (event_set) begin
      irq_pend_d = 1'b1;
    end

    if (cmd_en) begin
      case (cmd_op)
        OP_START: begin
          mem_addr_d  = cmd_addr;
          timeout_d   = cmd_timeout;
          cycles_d    = '0;
          state_d     = ST_RESET;
          core_rst_d  = 1'b1;
          core_exec_d = 1'b0;
          rst_cnt_d   = RST_LOAD;
          run_after_d = 1'b1;
          irq_pend_d  = irq_pend_q;
        end
        OP_RESET: begin
          state_d     = ST_RESET;
          core_rst_d  = 1'b1;
          core_exec_d = 1'b0;
          rst_cnt_d   = RST_LOAD;
          run_after_d = 1'b0;
          irq_pend_d  = irq_pend_q;
        end
        OP_ABORT: begin
          state_d     = ST_ABORT;
          core_rst_d  = 1'b0;
          core_exec_d = 1'b0;
          irq_pend_d  = irq_pend_q;
        end
        default: begin
          // A completion landing with CLRIRQ keeps the interrupt pending.
          if (!event_set) irq_pend_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      core_rst_q  <= 1'b1;
      core_exec_q <= 1'b0;
      mem_addr_q  <= '0;
      cycles_q    <= '0;
      timeout_q   <= '0;
      irq_pend_q  <= 1'b0;
      rst_cnt_q   <= '0;
      run_after_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_rst_q  <= core_rst_d;
      core_exec_q <= core_exec_d;
      mem_addr_q  <= mem_addr_d;
      cycles_q    <= cycles_d;
      timeout_q   <= timeout_d;
      irq_pend_q  <= irq_pend_d;
      rst_cnt_q   <= rst_cnt_d;
      run_after_q <= run_after_d;
    end
  end

  assign core_rst      = core_rst_q;
  assign core_exec     = core_exec_q;
  assign mem_addr      = mem_addr_q;
  assign state         = state_q;
  assign cycles        = cycles_q;
  assign irq_pend      = irq_pend_q;
  assign irq_pend_next = irq_pend_d;

endmodule

// File: rtl/multi_core_controller.sv
// Multi-core run-control sequencer: validates and routes commands to per-core
// state machines, flags rejected commands and aggregates interrupts.
module multi_core_controller
  import multi_core_controller_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int STAT_WIDTH = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int RST_CYCLES = 4,
  parameter int DONE_BIT   = 0,
  localparam int CW = core_idx_width(NUM_CORES)
) (
  input  logic                            CCLK,
  input  logic                            CRST,
  input  logic                            CMD_VALID,
  input  logic [1:0]                      CMD_OP,
  input  logic [CW-1:0]                   CMD_CORE,
  input  logic [ADDR_WIDTH-1:0]           CMD_ADDR,
  input  logic [CNT_WIDTH-1:0]            CMD_TIMEOUT,
  output logic                            CMD_ERR,
  output logic [NUM_CORES-1:0]            CORE_RST,
  output logic [NUM_CORES-1:0]            CORE_EXEC,
  output logic [NUM_CORES*ADDR_WIDTH-1:0] CORE_MEM_ADDR,
  input  logic [NUM_CORES*STAT_WIDTH-1:0] CORE_STAT,
  output logic [NUM_CORES*3-1:0]          STATE,
  output logic [NUM_CORES*CNT_WIDTH-1:0]  CYCLES,
  output logic [NUM_CORES-1:0]            IRQ_PEND,
  output logic                            IRQ
);

  op_e                  cmd_op;
  state_e               sel_state;
  logic                 op_legal;
  logic [NUM_CORES-1:0] cmd_en;
  logic [NUM_CORES-1:0] pend_next;
  logic [2**CW-1:0]     core_ok;
  logic                 cmd_err_q, cmd_err_d;
  logic                 irq_q, irq_d;

  assign cmd_op = op_e'(CMD_OP);

  // Index values the CMD_CORE field can encode but that have no core behind them.
  generate
    for (genvar gi = 0; gi < 2**CW; gi++) begin : g_core_ok
      assign core_ok[gi] = (gi < NUM_CORES);
    end
  endgenerate

  always_comb begin
    sel_state = ST_IDLE;
    op_legal  = 1'b0;
    cmd_en    = '0;
    cmd_err_d = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (CMD_CORE == CW'(i)) sel_state = state_e'(STATE[i*3 +: 3]);
    end
    case (cmd_op)
      OP_START: op_legal = (sel_state != ST_RESET) && (sel_state != ST_RUN);
      OP_ABORT: op_legal = (sel_state == ST_RESET) || (sel_state == ST_RUN);
      default:  op_legal = 1'b1;
    endcase
    if (CMD_VALID) begin
      if (!core_ok[CMD_CORE] || !op_legal) begin
        cmd_err_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (CMD_CORE == CW'(i)) cmd_en[i] = 1'b1;
        end
      end
    end
    irq_d = |pend_next;
  end

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      core_run_fsm #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .STAT_WIDTH(STAT_WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .RST_CYCLES(RST_CYCLES),
        .DONE_BIT  (DONE_BIT)
      ) u_fsm (
        .clk          (CCLK),
        .srst         (CRST),
        .cmd_en       (cmd_en[gi]),
        .cmd_op       (cmd_op),
        .cmd_addr     (CMD_ADDR),
        .cmd_timeout  (CMD_TIMEOUT),
        .core_stat    (CORE_STAT[gi*STAT_WIDTH +: STAT_WIDTH]),
        .core_rst     (CORE_RST[gi]),
        .core_exec    (CORE_EXEC[gi]),
        .mem_addr     (CORE_MEM_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH]),
        .state        (STATE[gi*3 +: 3]),
        .cycles       (CYCLES[gi*CNT_WIDTH +: CNT_WIDTH]),
        .irq_pend     (IRQ_PEND[gi]),
        .irq_pend_next(pend_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge CCLK) begin
    if (CRST) begin
      cmd_err_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cmd_err_q <= cmd_err_d;
      irq_q     <= irq_d;
    end
  end

  assign CMD_ERR = cmd_err_q;
  assign IRQ     = irq_q;

endmodule

// File: tb/tb_multi_core_controller.sv
// Directed bench for multi_core_controller: expectations queued at stimulus time,
// popped and asserted when the controller's registered outputs are sampled.
module tb_multi_core_controller;
  import multi_core_controller_pkg::*;

  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int AW = 32;
  localparam int SW = 8;
  localparam int TW = 32;

  logic          CCLK = 1'b0;
  logic          CRST = 1'b1;
  logic          CMD_VALID = 1'b0;
  logic          cmd_valid3 = 1'b0;
  logic [1:0]    CMD_OP = '0;
  logic [1:0]    CMD_CORE = '0;
  logic [AW-1:0] CMD_ADDR = '0;
  logic [TW-1:0] CMD_TIMEOUT = '0;
  logic [N*SW-1:0] CORE_STAT = '0;

  logic            CMD_ERR, IRQ;
  logic [N-1:0]    CORE_RST, CORE_EXEC, IRQ_PEND;
  logic [N*AW-1:0] CORE_MEM_ADDR;
  logic [N*3-1:0]  STATE;
  logic [N*TW-1:0] CYCLES;

  logic             cmd_err3, irq3;
  logic [N3-1:0]    core_rst3, core_exec3, irq_pend3;
  logic [N3*AW-1:0] core_mem_addr3;
  logic [N3*SW-1:0] core_stat3 = '0;
  logic [N3*3-1:0]  state3;
  logic [N3*TW-1:0] cycles3;

  multi_core_controller #(.NUM_CORES(N)) u_dut (
    .CCLK(CCLK), .CRST(CRST), .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP),
    .CMD_CORE(CMD_CORE), .CMD_ADDR(CMD_ADDR), .CMD_TIMEOUT(CMD_TIMEOUT),
    .CMD_ERR(CMD_ERR), .CORE_RST(CORE_RST), .CORE_EXEC(CORE_EXEC),
    .CORE_MEM_ADDR(CORE_MEM_ADDR), .CORE_STAT(CORE_STAT), .STATE(STATE),
    .CYCLES(CYCLES), .IRQ_PEND(IRQ_PEND), .IRQ(IRQ)
  );

  // Three-core instance so that CMD_CORE can name a core that does not exist.
  multi_core_controller #(.NUM_CORES(N3)) u_dut3 (
    .CCLK(CCLK), .CRST(CRST), .CMD_VALID(cmd_valid3), .CMD_OP(CMD_OP),
    .CMD_CORE(CMD_CORE), .CMD_ADDR(CMD_ADDR), .CMD_TIMEOUT(CMD_TIMEOUT),
    .CMD_ERR(cmd_err3), .CORE_RST(core_rst3), .CORE_EXEC(core_exec3),
    .CORE_MEM_ADDR(core_mem_addr3), .CORE_STAT(core_stat3), .STATE(state3),
    .CYCLES(cycles3), .IRQ_PEND(irq_pend3), .IRQ(irq3)
  );

  always #5 CCLK = ~CCLK;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb_q[$];

  task automatic expect_v(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h required=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [2:0] st(input int i);
    return STATE[i*3 +: 3];
  endfunction
  function automatic logic [TW-1:0] cyc(input int i);
    return CYCLES[i*TW +: TW];
  endfunction
  function automatic logic [AW-1:0] addr(input int i);
    return CORE_MEM_ADDR[i*AW +: AW];
  endfunction

  // Command is presented for one cycle; returns at the first cycle showing its effect.
  task automatic send(input op_e op, input logic [1:0] core, input logic [AW-1:0] a,
                      input logic [TW-1:0] tmo, input bit to3);
    CMD_OP      = op;
    CMD_CORE    = core;
    CMD_ADDR    = a;
    CMD_TIMEOUT = tmo;
    CMD_VALID   = !to3;
    cmd_valid3  = to3;
    @(negedge CCLK);
    CMD_VALID  = 1'b0;
    cmd_valid3 = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles
    repeat (3) @(negedge CCLK);
    expect_v("reset_core_rst", 4'hF);  observe(CORE_RST);
    expect_v("reset_core_exec", 4'h0); observe(CORE_EXEC);
    expect_v("reset_irq", 1'b0);       observe(IRQ);
    expect_v("reset_cmd_err", 1'b0);   observe(CMD_ERR);
    CRST = 1'b0;
    @(negedge CCLK);
    expect_v("release_core_rst", 4'h0); observe(CORE_RST);
    expect_v("release_state", 12'h0);   observe(STATE);
    expect_v("release_cycles", 128'h0); observe(CYCLES);

    // START core 2: four reset-hold cycles, then run until done after 10 cycles
    send(OP_START, 2'd2, 32'h1000, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      expect_v("c2_rst_hold", 1'b1);  observe(CORE_RST[2]);
      expect_v("c2_exec_hold", 1'b0); observe(CORE_EXEC[2]);
      expect_v("c2_state_reset", 3'd1); observe(st(2));
      @(negedge CCLK);
    end
    expect_v("c2_exec_run", 1'b1);     observe(CORE_EXEC[2]);
    expect_v("c2_rst_run", 1'b0);      observe(CORE_RST[2]);
    expect_v("c2_addr", 32'h1000);     observe(addr(2));
    expect_v("c2_state_run", 3'd2);    observe(st(2));
    repeat (9) @(negedge CCLK);
    CORE_STAT[2*SW] = 1'b1;
    @(negedge CCLK);
    CORE_STAT = '0;
    expect_v("c2_state_done", 3'd3);   observe(st(2));
    expect_v("c2_cycles", 32'd10);     observe(cyc(2));
    expect_v("c2_exec_off", 1'b0);     observe(CORE_EXEC[2]);
    expect_v("c2_irq", 1'b1);          observe(IRQ);
    expect_v("c2_irq_pend", 4'b0100);  observe(IRQ_PEND);
    send(OP_CLRIRQ, 2'd2, '0, '0, 1'b0);
    expect_v("c2_clrirq_pend", 4'b0000); observe(IRQ_PEND);
    expect_v("c2_clrirq_irq", 1'b0);     observe(IRQ);

    // START core 0 with a 20-cycle watchdog and no completion
    send(OP_START, 2'd0, 32'h2000, 32'd20, 1'b0);
    repeat (4) @(negedge CCLK);
    repeat (19) @(negedge CCLK);
    expect_v("c0_state_before_tmo", 3'd2); observe(st(0));
    expect_v("c0_cycles_before_tmo", 32'd19); observe(cyc(0));
    @(negedge CCLK);
    expect_v("c0_state_timeout", 3'd4); observe(st(0));
    expect_v("c0_cycles_timeout", 32'd20); observe(cyc(0));
    expect_v("c0_exec_off", 1'b0);      observe(CORE_EXEC[0]);
    expect_v("c0_irq_pend", 4'b0001);   observe(IRQ_PEND);
    @(negedge CCLK);
    expect_v("c0_cycles_hold", 32'd20); observe(cyc(0));
    send(OP_CLRIRQ, 2'd0, '0, '0, 1'b0);
    expect_v("c0_clrirq_irq", 1'b0);    observe(IRQ);

    // ABORT core 1 mid-run, then a second ABORT is rejected
    send(OP_START, 2'd1, 32'h3000, 32'd0, 1'b0);
    repeat (6) @(negedge CCLK);
    send(OP_ABORT, 2'd1, '0, '0, 1'b0);
    expect_v("c1_abort_exec", 1'b0);    observe(CORE_EXEC[1]);
    expect_v("c1_abort_rst", 1'b0);     observe(CORE_RST[1]);
    expect_v("c1_abort_state", 3'd5);   observe(st(1));
    expect_v("c1_abort_no_irq", 4'b0000); observe(IRQ_PEND);
    expect_v("c1_abort_no_err", 1'b0);  observe(CMD_ERR);
    send(OP_ABORT, 2'd1, '0, '0, 1'b0);
    expect_v("c1_reabort_err", 1'b1);   observe(CMD_ERR);
    expect_v("c1_reabort_state", 3'd5); observe(st(1));
    @(negedge CCLK);
    expect_v("c1_err_pulse_end", 1'b0); observe(CMD_ERR);

    // START core 3 while running is rejected; out-of-range core is rejected
    send(OP_START, 2'd3, 32'h4000, 32'd0, 1'b0);
    repeat (5) @(negedge CCLK);
    expect_v("c3_state_run", 3'd2);     observe(st(3));
    send(OP_START, 2'd3, 32'hDEAD, 32'd0, 1'b0);
    expect_v("c3_restart_err", 1'b1);   observe(CMD_ERR);
    expect_v("c3_restart_state", 3'd2); observe(st(3));
    expect_v("c3_restart_addr", 32'h4000); observe(addr(3));
    expect_v("c3_restart_exec", 1'b1);  observe(CORE_EXEC[3]);
    send(OP_START, 2'd3, 32'h5555, 32'd0, 1'b1);
    expect_v("range_err", 1'b1);        observe(cmd_err3);
    expect_v("range_state", 9'h0);     observe(state3);
    expect_v("range_exec", 3'b000);     observe(core_exec3);
    expect_v("range_other_err", 1'b0);  observe(CMD_ERR);

    // Completion and CLRIRQ on the same cycle keep the interrupt pending
    CORE_STAT[3*SW] = 1'b1;
    send(OP_CLRIRQ, 2'd3, '0, '0, 1'b0);
    CORE_STAT = '0;
    expect_v("c3_done_state", 3'd3);    observe(st(3));
    expect_v("c3_pend_kept", 4'b1000);  observe(IRQ_PEND);
    expect_v("c3_irq_kept", 1'b1);      observe(IRQ);

    // RESET op from DONE: hold reset, return to IDLE, keep address and pending IRQ
    send(OP_RESET, 2'd3, '0, '0, 1'b0);
    expect_v("c3_reset_state", 3'd1);   observe(st(3));
    expect_v("c3_reset_rst", 1'b1);     observe(CORE_RST[3]);
    repeat (4) @(negedge CCLK);
    expect_v("c3_reset_idle", 3'd0);    observe(st(3));
    expect_v("c3_reset_rst_off", 1'b0); observe(CORE_RST[3]);
    expect_v("c3_reset_pend", 4'b1000); observe(IRQ_PEND);
    expect_v("c3_reset_addr", 32'h4000); observe(addr(3));

    // Completion and timeout on the same cycle: completion wins
    send(OP_START, 2'd0, 32'h6000, 32'd3, 1'b0);
    repeat (4) @(negedge CCLK);
    repeat (2) @(negedge CCLK);
    CORE_STAT[0] = 1'b1;
    @(negedge CCLK);
    CORE_STAT = '0;
    expect_v("c0_both_state", 3'd3);    observe(st(0));
    expect_v("c0_both_cycles", 32'd3);  observe(cyc(0));

    // Reset in the middle of activity
    CRST = 1'b1;
    @(negedge CCLK);
    CRST = 1'b0;
    expect_v("midrst_core_rst", 4'hF);  observe(CORE_RST);
    expect_v("midrst_state", 12'h0);    observe(STATE);
    expect_v("midrst_irq_pend", 4'h0);  observe(IRQ_PEND);
    expect_v("midrst_irq", 1'b0);       observe(IRQ);
    expect_v("midrst_addr", 128'h0);    observe(CORE_MEM_ADDR);
    expect_v("midrst_cycles", 128'h0);  observe(CYCLES);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
